// File: rtl/mycounter_pkg.sv
// Shared defaults and types for the modulo counter family.
package mycounter_pkg;

  localparam int unsigned MYCOUNTER_DEF_WIDTH = 4;
  localparam int unsigned MYCOUNTER_DEF_RESET = 0;

  typedef logic [MYCOUNTER_DEF_WIDTH-1:0] count_t;

endpackage

// File: rtl/mycounter_next.sv
// Combinational next-state logic for the modulo counter: next count and next terminal flag.
module mycounter_next
  import mycounter_pkg::*;
#(
  parameter int unsigned WIDTH   = MYCOUNTER_DEF_WIDTH,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             next_tc
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  // Terminal and out-of-range counts both fall through to the zero default.
  always_comb begin
    next_count = '0;
    if (load) begin
      next_count = load_val;
    end else if (count < MAX_C) begin
      next_count = count + ONE_C;
    end
    next_tc = (next_count == MAX_C);
  end

endmodule

// File: rtl/my_counter_4bit.sv
// Free-running modulo counter with registered terminal-count flag for cascading.
// Define MYCOUNTER_LOAD_EN to add the LOAD/LOAD_VAL synchronous parallel load.
module my_counter_4bit
  import mycounter_pkg::*;
#(
  parameter int unsigned WIDTH     = MYCOUNTER_DEF_WIDTH,
  parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int unsigned RESET_VAL = MYCOUNTER_DEF_RESET
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef MYCOUNTER_LOAD_EN
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
`endif
  output logic [WIDTH-1:0] out,
  output logic             TC
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_count;
  logic             next_tc;

`ifdef MYCOUNTER_LOAD_EN
  assign load     = LOAD;
  assign load_val = LOAD_VAL;
`else
  assign load     = 1'b0;
  assign load_val = '0;
`endif

  mycounter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count      (out),
    .load       (load),
    .load_val   (load_val),
    .next_count (next_count),
    .next_tc    (next_tc)
  );

  // TC is registered from the next value so it always equals (out == MAX_VAL).
  always_ff @(posedge CLK) begin
    if (RST) begin
      out <= RESET_C;
      TC  <= (RESET_C == MAX_C);
    end else begin
      out <= next_count;
      TC  <= next_tc;
    end
  end

endmodule

// File: tb/tb_my_counter_4bit.sv
// Directed bench for my_counter_4bit: default, MAX_VAL=9 and RESET_VAL=9 instances side by side.
`timescale 1us / 1ns
module tb_my_counter_4bit;

  logic       CLK;
  logic       RST;
  logic       LOAD;
  logic [3:0] LOAD_VAL;

  logic [3:0] out_def, out_m9, out_r9;
  logic       tc_def, tc_m9, tc_r9;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  my_counter_4bit u_def (
    .CLK      (CLK),
    .RST      (RST),
`ifdef MYCOUNTER_LOAD_EN
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
`endif
    .out      (out_def),
    .TC       (tc_def)
  );

  my_counter_4bit #(.MAX_VAL(9)) u_m9 (
    .CLK      (CLK),
    .RST      (RST),
`ifdef MYCOUNTER_LOAD_EN
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
`endif
    .out      (out_m9),
    .TC       (tc_m9)
  );

  my_counter_4bit #(.MAX_VAL(9), .RESET_VAL(9)) u_r9 (
    .CLK      (CLK),
    .RST      (RST),
`ifdef MYCOUNTER_LOAD_EN
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
`endif
    .out      (out_r9),
    .TC       (tc_r9)
  );

  // driver tasks
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    RST      = 1'b1;
    LOAD     = 1'b0;
    LOAD_VAL = 4'd0;

    // Two reset edges from the unknown power-up state
    @(posedge CLK);
    step();
    check("rst_def_out", out_def, 4'd0);
    check("rst_def_tc", {3'b0, tc_def}, 4'd0);
    check("rst_m9_out", out_m9, 4'd0);
    check("rst_r9_out", out_r9, 4'd9);
    check("rst_r9_tc", {3'b0, tc_r9}, 4'd1);

    // Free run: 20 edges after release
    RST = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      e = 4'(i % 16);
      check("run_def_out", out_def, e);
      check("run_def_tc", {3'b0, tc_def}, (e == 4'd15) ? 4'd1 : 4'd0);
      e = 4'(i % 10);
      check("run_m9_out", out_m9, e);
      check("run_m9_tc", {3'b0, tc_m9}, (e == 4'd9) ? 4'd1 : 4'd0);
      e = 4'((i - 1) % 10);
      check("run_r9_out", out_r9, e);
    end

    // Advance the default counter from 4 up to 9
    for (int i = 5; i <= 9; i++) begin
      step();
      check("pre_mid_def_out", out_def, 4'(i));
    end

    // Reset pulsed for one cycle at out == 9
    RST = 1'b1;
    step();
    check("mid_rst_def_out", out_def, 4'd0);
    check("mid_rst_def_tc", {3'b0, tc_def}, 4'd0);
    check("mid_rst_m9_out", out_m9, 4'd0);
    check("mid_rst_r9_out", out_r9, 4'd9);
    check("mid_rst_r9_tc", {3'b0, tc_r9}, 4'd1);
    RST = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("post_rst_def_out", out_def, 4'(k));
      check("post_rst_m9_out", out_m9, 4'(k));
      check("post_rst_r9_out", out_r9, 4'(k - 1));
    end

`ifdef MYCOUNTER_LOAD_EN
    // Load 14: default goes 14,15,0; MAX_VAL=9 sees it as out of range
    LOAD     = 1'b1;
    LOAD_VAL = 4'd14;
    step();
    check("ld14_def_out", out_def, 4'd14);
    check("ld14_def_tc", {3'b0, tc_def}, 4'd0);
    check("ld14_m9_out", out_m9, 4'd14);
    check("ld14_m9_tc", {3'b0, tc_m9}, 4'd0);
    LOAD = 1'b0;
    step();
    check("ld14_n1_def_out", out_def, 4'd15);
    check("ld14_n1_def_tc", {3'b0, tc_def}, 4'd1);
    check("ld14_n1_m9_out", out_m9, 4'd0);
    check("ld14_n1_m9_tc", {3'b0, tc_m9}, 4'd0);
    step();
    check("ld14_n2_def_out", out_def, 4'd0);
    check("ld14_n2_def_tc", {3'b0, tc_def}, 4'd0);

    // Out-of-range load 12 with MAX_VAL=9
    LOAD     = 1'b1;
    LOAD_VAL = 4'd12;
    step();
    check("ld12_m9_out", out_m9, 4'd12);
    check("ld12_m9_tc", {3'b0, tc_m9}, 4'd0);
    LOAD = 1'b0;
    step();
    check("ld12_n1_m9_out", out_m9, 4'd0);
    check("ld12_n1_def_out", out_def, 4'd13);

    // Reset wins over load
    RST      = 1'b1;
    LOAD     = 1'b1;
    LOAD_VAL = 4'd7;
    step();
    check("prio_def_out", out_def, 4'd0);
    check("prio_def_tc", {3'b0, tc_def}, 4'd0);
    check("prio_m9_out", out_m9, 4'd0);
    check("prio_r9_out", out_r9, 4'd9);
    RST  = 1'b0;
    LOAD = 1'b0;
    step();
    check("prio_n1_def_out", out_def, 4'd1);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
